// File: rtl/alarm_time_keeper.sv
// alarm_time_keeper
// Holds the 24-hour BCD time of day and the alarm time for the alarm clock.
// The time advances on a one-minute tick. Keypad digits shift into a
// four-digit entry buffer, which can be committed to either register once it
// passes a legality check. Every output is registered.
module alarm_time_keeper #(
    parameter logic [15:0] RESET_TIME  = 16'h0000,
    parameter logic [15:0] RESET_ALARM = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        one_minute,
    input  logic        key_valid,
    input  logic [3:0]  key_digit,
    input  logic        clear_keys,
    input  logic        load_time,
    input  logic        load_alarm,
    output logic [15:0] current_time,
    output logic [15:0] alarm_time,
    output logic [15:0] key_buffer,
    output logic        load_ack,
    output logic        load_err,
    output logic        minute_wrap
);

    logic        buffer_legal;
    logic [15:0] time_inc;
    logic        inc_wraps;

    // Legality of the entry buffer as an HHMM value
    always_comb begin
        buffer_legal = 1'b1;
        if (key_buffer[15:12] > 4'd2)
            buffer_legal = 1'b0;
        if (key_buffer[15:12] == 4'd2 && key_buffer[11:8] > 4'd3)
            buffer_legal = 1'b0;
        if (key_buffer[11:8] > 4'd9)
            buffer_legal = 1'b0;
        if (key_buffer[7:4] > 4'd5)
            buffer_legal = 1'b0;
        if (key_buffer[3:0] > 4'd9)
            buffer_legal = 1'b0;
    end

    // Per-digit BCD increment of the current time, with midnight rollover
    always_comb begin
        time_inc  = current_time;
        inc_wraps = 1'b0;
        if (current_time == 16'h2359) begin
            // 23 is not a carry point for ls_hour, so midnight is handled
            // as a whole-value case instead of through the digit chain.
            time_inc  = 16'h0000;
            inc_wraps = 1'b1;
        end else if (current_time[3:0] != 4'd9) begin
            time_inc[3:0] = current_time[3:0] + 4'd1;
        end else begin
            time_inc[3:0] = 4'd0;
            if (current_time[7:4] != 4'd5) begin
                time_inc[7:4] = current_time[7:4] + 4'd1;
            end else begin
                time_inc[7:4] = 4'd0;
                if (current_time[11:8] != 4'd9) begin
                    time_inc[11:8] = current_time[11:8] + 4'd1;
                end else begin
                    time_inc[11:8]  = 4'd0;
                    time_inc[15:12] = current_time[15:12] + 4'd1;
                end
            end
        end
    end

    // Register update: commits, key entry and minute ticks in priority order
    always_ff @(posedge clk) begin
        if (reset) begin
            current_time <= RESET_TIME;
            alarm_time   <= RESET_ALARM;
            key_buffer   <= 16'h0000;
            load_ack     <= 1'b0;
            load_err     <= 1'b0;
            minute_wrap  <= 1'b0;
        end else begin
            load_ack    <= 1'b0;
            load_err    <= 1'b0;
            minute_wrap <= 1'b0;

            // A commit owns the buffer for this cycle, so a same-cycle clear
            // or digit is dropped whether or not the commit is accepted.
            if (load_time) begin
                if (buffer_legal) begin
                    current_time <= key_buffer;
                    key_buffer   <= 16'h0000;
                    load_ack     <= 1'b1;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (load_alarm) begin
                if (buffer_legal) begin
                    alarm_time <= key_buffer;
                    key_buffer <= 16'h0000;
                    load_ack   <= 1'b1;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (clear_keys) begin
                key_buffer <= 16'h0000;
            end else if (key_valid) begin
                if (key_digit <= 4'd9)
                    key_buffer <= {key_buffer[11:0], key_digit};
                else
                    load_err <= 1'b1;
            end

            // An accepted time load overrides the tick; otherwise it applies.
            if (one_minute && !(load_time && buffer_legal)) begin
                current_time <= time_inc;
                minute_wrap  <= inc_wraps;
            end
        end
    end

endmodule

// File: tb/tb_alarm_time_keeper.sv
// Testbench for alarm_time_keeper: directed scenarios followed by random
// stimulus, all checked against a minutes-based behavioural model.
module tb_alarm_time_keeper;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        one_minute = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_digit = 4'd0;
    logic        clear_keys = 1'b0;
    logic        load_time = 1'b0;
    logic        load_alarm = 1'b0;
    logic [15:0] current_time;
    logic [15:0] alarm_time;
    logic [15:0] key_buffer;
    logic        load_ack;
    logic        load_err;
    logic        minute_wrap;

    int errors = 0;
    int checks = 0;
    int wrap_seen;

    logic [15:0] m_time, m_alarm, m_buf;
    logic        m_ack, m_err, m_wrap;

    alarm_time_keeper dut (
        .clk          (clk),
        .reset        (reset),
        .one_minute   (one_minute),
        .key_valid    (key_valid),
        .key_digit    (key_digit),
        .clear_keys   (clear_keys),
        .load_time    (load_time),
        .load_alarm   (load_alarm),
        .current_time (current_time),
        .alarm_time   (alarm_time),
        .key_buffer   (key_buffer),
        .load_ack     (load_ack),
        .load_err     (load_err),
        .minute_wrap  (minute_wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int to_minutes(input logic [15:0] t);
        return int'(t[15:12]) * 600 + int'(t[11:8]) * 60 + int'(t[7:4]) * 10 + int'(t[3:0]);
    endfunction

    function automatic logic [15:0] from_minutes(input int m);
        int h, mm;
        h  = m / 60;
        mm = m % 60;
        return {4'(h / 10), 4'(h % 10), 4'(mm / 10), 4'(mm % 10)};
    endfunction

    function automatic bit is_legal(input logic [15:0] b);
        int hh, mm;
        if (b[15:12] > 9 || b[11:8] > 9 || b[7:4] > 9 || b[3:0] > 9)
            return 1'b0;
        hh = int'(b[15:12]) * 10 + int'(b[11:8]);
        mm = int'(b[7:4]) * 10 + int'(b[3:0]);
        return (hh < 24) && (mm < 60);
    endfunction

    // Advance the model by one clock using the currently driven inputs.
    task automatic model_step();
        bit tick_ok;
        int mins;
        if (reset) begin
            m_time = 16'h0000; m_alarm = 16'h0000; m_buf = 16'h0000;
            m_ack = 0; m_err = 0; m_wrap = 0;
        end else begin
            m_ack = 0; m_err = 0; m_wrap = 0;
            tick_ok = one_minute;
            if (load_time) begin
                if (is_legal(m_buf)) begin
                    m_time = m_buf; m_buf = 0; m_ack = 1; tick_ok = 0;
                end else m_err = 1;
            end else if (load_alarm) begin
                if (is_legal(m_buf)) begin
                    m_alarm = m_buf; m_buf = 0; m_ack = 1;
                end else m_err = 1;
            end else if (clear_keys) begin
                m_buf = 0;
            end else if (key_valid) begin
                if (key_digit <= 9) m_buf = {m_buf[11:0], key_digit};
                else m_err = 1;
            end
            if (tick_ok) begin
                mins = to_minutes(m_time) + 1;
                if (mins == 1440) begin
                    mins = 0;
                    m_wrap = 1;
                end
                m_time = from_minutes(mins);
            end
        end
    endtask

    // One clock: update model, wait past the edge, compare, drop strobes.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("current_time", current_time, m_time);
        check("alarm_time", alarm_time, m_alarm);
        check("key_buffer", key_buffer, m_buf);
        check("load_ack", {15'd0, load_ack}, {15'd0, m_ack});
        check("load_err", {15'd0, load_err}, {15'd0, m_err});
        check("minute_wrap", {15'd0, minute_wrap}, {15'd0, m_wrap});
        if (minute_wrap) wrap_seen++;
        reset = 0; one_minute = 0; key_valid = 0; clear_keys = 0;
        load_time = 0; load_alarm = 0; key_digit = 0;
    endtask

    task automatic key(input logic [3:0] d);
        key_valid = 1; key_digit = d;
        cycle();
    endtask

    task automatic keys4(input logic [15:0] v);
        key(v[15:12]); key(v[11:8]); key(v[7:4]); key(v[3:0]);
    endtask

    initial begin
        #2;
        reset = 1;
        cycle();
        check("reset_time", current_time, 16'h0000);
        check("reset_buffer", key_buffer, 16'h0000);

        // 60 ticks from midnight reach 01:00 without a wrap
        wrap_seen = 0;
        for (int i = 0; i < 60; i++) begin
            one_minute = 1;
            cycle();
        end
        check("sixty_ticks", current_time, 16'h0100);
        check("no_wrap_60", 16'(wrap_seen), 16'd0);

        // Load 23:59 then tick into midnight
        keys4(16'h2359);
        load_time = 1;
        cycle();
        check("load_2359", current_time, 16'h2359);
        check("load_2359_ack", {15'd0, load_ack}, 16'd1);
        check("load_2359_buf", key_buffer, 16'h0000);
        cycle();
        check("ack_one_cycle", {15'd0, load_ack}, 16'd0);
        one_minute = 1;
        cycle();
        check("midnight", current_time, 16'h0000);
        check("midnight_wrap", {15'd0, minute_wrap}, 16'd1);
        cycle();
        check("wrap_one_cycle", {15'd0, minute_wrap}, 16'd0);

        // Illegal alarm 24:00 rejected, then 06:30 accepted
        keys4(16'h2400);
        load_alarm = 1;
        cycle();
        check("alarm_2400_err", {15'd0, load_err}, 16'd1);
        check("alarm_2400_keep", alarm_time, 16'h0000);
        check("alarm_2400_buf", key_buffer, 16'h2400);
        keys4(16'h0630);
        load_alarm = 1;
        cycle();
        check("alarm_0630", alarm_time, 16'h0630);

        // Accepted load beats a same-cycle tick
        keys4(16'h0959); load_time = 1; cycle();
        keys4(16'h1200); load_time = 1; one_minute = 1; cycle();
        check("load_beats_tick", current_time, 16'h1200);
        // Rejected load lets the tick through
        keys4(16'h0959); load_time = 1; cycle();
        keys4(16'h2500); load_time = 1; one_minute = 1; cycle();
        check("tick_after_reject", current_time, 16'h1000);
        check("reject_err", {15'd0, load_err}, 16'd1);

        // Illegal key code, then clear racing a digit
        clear_keys = 1; cycle();
        key(4'd3);
        key(4'd12);
        check("key12_err", {15'd0, load_err}, 16'd1);
        check("key12_buf", key_buffer, 16'h0003);
        clear_keys = 1; key_valid = 1; key_digit = 4'd7; cycle();
        check("clear_wins", key_buffer, 16'h0000);

        // Reset during entry and commit
        key(4'd1); key(4'd2);
        reset = 1; load_time = 1; cycle();
        check("reset_mid_time", current_time, 16'h0000);
        check("reset_mid_buf", key_buffer, 16'h0000);
        check("reset_mid_ack", {15'd0, load_ack}, 16'd0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 199) == 0);
            load_time  = ($urandom_range(0, 15) == 0);
            load_alarm = ($urandom_range(0, 15) == 0);
            clear_keys = ($urandom_range(0, 19) == 0);
            key_valid  = ($urandom_range(0, 1) == 0);
            key_digit  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                      : 4'($urandom_range(0, 9));
            one_minute = ($urandom_range(0, 2) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alarm_time_keeper.md
# alarm_time_keeper

Source of the alarm clock's time values. It keeps the 24-hour BCD time of day and advances it on a one-minute tick. It accepts keypad digits into a 4-digit entry buffer and commits that buffer to either the current time or the alarm time after a legality check. Its `current_time`, `alarm_time` and `key_buffer` outputs feed the display/alarm driver, which compares the times and selects what is shown.

## Interface
Parameters:
- `RESET_TIME`, default 16'h0000: BCD HHMM loaded into `current_time` on reset.
- `RESET_ALARM`, default 16'h0000: BCD HHMM loaded into `alarm_time` on reset.

Ports:
- `clk` input 1: single system clock; all logic is on the rising edge.
- `reset` input 1: **synchronous, active-high** reset.
- `one_minute` input 1: one-cycle pulse that advances the time by one minute.
- `key_valid` input 1: one-cycle strobe qualifying `key_digit`.
- `key_digit` input 4: keypad code; 0–9 are digits, 10–15 are illegal.
- `clear_keys` input 1: clears the entry buffer.
- `load_time` input 1: commits the buffer to `current_time`.
- `load_alarm` input 1: commits the buffer to `alarm_time`.
- `current_time` output 16: BCD {ms_hour, ls_hour, ms_min, ls_min}.
- `alarm_time` output 16: BCD alarm time, same format.
- `key_buffer` output 16: digits entered so far; the newest digit is in [3:0].
- `load_ack` output 1: one-cycle pulse, commit accepted.
- `load_err` output 1: one-cycle pulse, commit rejected or illegal key.
- `minute_wrap` output 1: one-cycle pulse when the time wraps 23:59 → 00:00.

## Operation
- Reset values:
  - `current_time` = RESET_TIME, `alarm_time` = RESET_ALARM.
  - `key_buffer` = 0.
  - `load_ack`, `load_err` and `minute_wrap` = 0.
- Key entry, on `key_valid`:
  - digit 0–9: `key_buffer` <= {key_buffer[11:0], digit}. The oldest digit is dropped, so there is no overflow condition.
  - digit 10–15: buffer unchanged and `load_err` pulses.
- Legal time: ms_hour ≤ 2; ls_hour ≤ 9, or ≤ 3 when ms_hour = 2; ms_min ≤ 5; ls_min ≤ 9.
- Commit, on `load_time` or `load_alarm`:
  - buffer legal: write the buffer to the target register, clear the buffer, pulse `load_ack`.
  - buffer illegal: target unchanged, buffer retained, pulse `load_err`.
- Minute advance, on `one_minute`, per-digit BCD increment with carry:
  - ls_min 9 → 0 with carry into ms_min.
  - ms_min 5 → 0 with carry into the hour.
  - ls_hour 9 → 0 with ms_hour + 1.
  - 23:59 → 00:00, and `minute_wrap` pulses in that cycle.
- Per-cycle priority: `reset` > `load_time` > `load_alarm` > `clear_keys` > `key_valid`. `one_minute` is evaluated independently, with these exceptions:
  - `load_time` with `one_minute`: an accepted load wins and the tick is discarded. A rejected load lets the tick apply.
  - `load_time` with `load_alarm`: only `load_time` is acted on.
  - `clear_keys` with `key_valid`: clear wins and the digit is discarded.
  - Any accepted commit clears the buffer and discards a same-cycle `key_valid`.
- `alarm_time` changes only through reset or an accepted `load_alarm`. A tick never alters it.
- An illegal stored time cannot occur: both registers only ever receive legal values (RESET_* must be legal).

## Timing
- All outputs are registered. Effects are visible on the cycle after the qualifying input edge.
- `load_ack`, `load_err` and `minute_wrap` are high for exactly one cycle per event and are never asserted together with reset.
- Back-to-back strobes on consecutive cycles are each processed: one digit per cycle, one tick per cycle.
- Reset asserted mid-entry or mid-commit:
  - all state returns to reset values on the next edge;
  - pending inputs in the reset cycle are ignored;
  - no pulse is emitted.
- Holding `key_valid` high for N cycles enters N digits. The block does no edge detection; callers supply single-cycle strobes.

## Test plan
- Reset, then 60 `one_minute` pulses → `current_time` = 16'h0100 and `minute_wrap` never pulses.
- Keys 2,3,5,9, `load_time`, then 1 tick → after the load, `current_time` = 16'h2359, `load_ack` = 1 for one cycle and `key_buffer` = 0. After the tick, `current_time` = 16'h0000 and `minute_wrap` = 1 for one cycle.
- Keys 2,4,0,0 then `load_alarm` → `load_err` pulse, `alarm_time` unchanged, `key_buffer` = 16'h2400. Then keys 0,6,3,0 and `load_alarm` → `alarm_time` = 16'h0630.
- `current_time` = 16'h0959 with `load_time` (buffer 16'h1200) and `one_minute` in the same cycle → 16'h1200, not 16'h1000. Repeat with an illegal buffer → 16'h1000 and `load_err` pulse.
- Key 12 → `load_err` pulse, buffer unchanged. `clear_keys` together with key 7 → buffer = 0.
- Keys 1,2 entered, reset asserted together with `load_time` → `current_time` = RESET_TIME, buffer = 0, no `load_ack`.
